mix_columns_seq: RTL and testbench
==================================

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 SHALL have parameter FWD_ROW, default 16'h2311, giving the four 4-bit forward MixColumns coefficients for row 0.
REQ-002 SHALL have parameter INV_ROW, default 16'hEBD9, giving the four 4-bit inverse MixColumns coefficients for row 0.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_state and in_inverse are valid.
REQ-007 in_ready  output  1  block can accept a state.
REQ-008 in_state  input  128  AES state, column-major; byte(r,c) = in_state[127-8*(4c+r) -: 8].
REQ-009 in_inverse  input  1  0 = MixColumns, 1 = InvMixColumns.
REQ-010 out_valid  output  1  out_state is valid.
REQ-011 out_ready  input  1  consumer accepts out_state.
REQ-012 out_state  output  128  result state, same byte ordering as in_state.
REQ-013 busy  output  1  high in RUN and DONE.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1; on in_valid, SHALL latch in_state and in_inverse, clear the column counter to 0, and go to RUN.
REQ-016 RUN: each cycle SHALL process column col (2-bit counter) and write 4 result bytes into the output register at column col.
REQ-017 Result byte(r,col) SHALL be the GF(2^8) dot product (XOR of products, polynomial 0x11B) of input column col with the coefficient row for r.
REQ-018 The coefficient row for r SHALL be the selected base (FWD_ROW or INV_ROW, per the latched in_inverse) rotated right by 4*r bits.
REQ-019 The column counter SHALL increment every RUN cycle; after col=3 is written, the FSM SHALL go to DONE, so the result is available 4 cycles after acceptance.
REQ-020 DONE: out_valid=1 and out_state SHALL hold stable until out_ready=1; on out_ready the FSM SHALL return to IDLE.
REQ-021 out_valid and out_ready being high in the same cycle SHALL complete the transfer; in_ready SHALL rise the following cycle (no same-cycle accept in DONE).
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and SHALL NOT corrupt the latched data.
REQ-023 Changes to in_inverse or in_state after acceptance SHALL have no effect on the block in flight.
REQ-024 out_state SHALL be the output register at all times; its value outside DONE is not meaningful.

Reset
REQ-025 rst SHALL force IDLE, col=0, out_valid=0, out_state=0, the latched state to 0 and the latched inverse flag to 0.
REQ-026 After reset, in_ready SHALL be 1 from the first cycle.
REQ-027 rst in RUN or DONE SHALL abort the block with no output produced, and SHALL take priority over in_valid and out_ready.

Structure
REQ-028 The FWD_ROW/INV_ROW defaults and the FSM state encoding SHALL live in a shared package aes_pkg.
REQ-029 The 4 per-row products SHALL be computed by four instances of the existing multiplicationcolumn sub-module (32-bit column, 16-bit coefficient row, 8-bit byte); no other sub-modules.
REQ-030 The combinational path SHALL be limited to one column per cycle: 4 multiplicationcolumn instances, with no 16-byte parallel datapath.

Verification
REQ-031 Forward: in_state=db135345_f20a225c_01010101_c6c6c6c6, in_inverse=0 -> out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid exactly 4 cycles after the accept.
REQ-032 Inverse: in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, in_inverse=1 -> out_state=db135345_f20a225c_01010101_c6c6c6c6.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new data -> out_state stable, in_ready=0, and the second state is accepted only after the out_ready handshake.
REQ-034 Vector d4d4d4d5_2d26314c_00000000_ffffffff forward -> d5d5d7d6_4d7ebdf8_00000000_ffffffff; a back-to-back second block gives the correct result with 1 idle cycle between blocks.
REQ-035 Assert rst at RUN col=2 -> next cycle IDLE, out_valid=0, out_state=0, in_ready=1; a following vector yields the correct result.
REQ-036 Randomised: 1000 states with random in_inverse and random ready gaps -> match a reference model; forward followed by inverse returns the original state.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: default MixColumns coefficient rows, FSM state
// encoding and the small GF(2^8) helpers used by the column multipliers.
package aes_pkg;

   // Row 0 of the forward matrix {02,03,01,01} and the inverse matrix
   // {0E,0B,0D,09}, one 4-bit coefficient per nibble, leftmost nibble first.
   localparam logic [15:0] FWD_ROW_DEFAULT = 16'h2311;
   localparam logic [15:0] INV_ROW_DEFAULT = 16'hEBD9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mc_state_t;

   // Multiply by x modulo the AES polynomial 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // Multiply a byte by a 4-bit constant; all MixColumns coefficients fit
   // in four bits, so four shift/xor steps are enough.
   function automatic logic [7:0] gf_mul4(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] acc;
      logic [7:0] x;
      acc = '0;
      x   = a;
      for (int i = 0; i < 4; i++) begin
         if (k[i]) acc = acc ^ x;
         x = xtime(x);
      end
      return acc;
   endfunction

   // Rotate a coefficient row right by 4*r bits, giving the row for matrix
   // row r from the row-0 base (the matrices are circulant).
   function automatic logic [15:0] row_rotr(input logic [15:0] row, input logic [1:0] r);
      logic [31:0] dbl;
      dbl = {row, row};
      return dbl[{r, 2'b00} +: 16];
   endfunction

endpackage

// File: rtl/multiplicationcolumn.sv
// One output byte of MixColumns: the GF(2^8) dot product of a 4-byte column
// with a 4-nibble coefficient row. Byte 0 of the column is the top byte.
module multiplicationcolumn
   import aes_pkg::*;
(
   input  logic [31:0] column,
   input  logic [15:0] coef,
   output logic [7:0]  result
);

   // XOR of the four per-byte products.
   always_comb begin
      result = gf_mul4(column[31:24], coef[15:12])
             ^ gf_mul4(column[23:16], coef[11:8])
             ^ gf_mul4(column[15:8],  coef[7:4])
             ^ gf_mul4(column[7:0],   coef[3:0]);
   end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns / InvMixColumns: one column per cycle through four
// byte multipliers, result held in DONE until the consumer takes it.
module mix_columns_seq
   import aes_pkg::*;
#(
   parameter logic [15:0] FWD_ROW = FWD_ROW_DEFAULT,
   parameter logic [15:0] INV_ROW = INV_ROW_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_inverse,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   mc_state_t    state_q;
   mc_state_t    state_d;
   logic [1:0]   col_q;
   logic [127:0] data_q;
   logic         inverse_q;
   logic [127:0] result_q;
   logic         accept;
   logic         run_step;
   logic [15:0]  base_row;
   logic [31:0]  cur_col;
   logic [31:0]  col_result;

   // State register; reset always wins, aborting any block in flight.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and handshake outputs. DONE only returns to IDLE, so a new
   // block can never be accepted in the same cycle as the output transfer.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      run_step  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy     = 1'b1;
            run_step = 1'b1;
            if (col_q == 2'd3) state_d = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pick the column currently being processed from the latched input.
   always_comb begin
      cur_col = data_q[127:96];
      case (col_q)
         2'd1:    cur_col = data_q[95:64];
         2'd2:    cur_col = data_q[63:32];
         2'd3:    cur_col = data_q[31:0];
         default: cur_col = data_q[127:96];
      endcase
   end

   assign base_row = inverse_q ? INV_ROW : FWD_ROW;

   // One multiplier per output row; row r uses the base rotated by r nibbles.
   for (genvar r = 0; r < 4; r++) begin : g_row
      logic [15:0] row_coef;
      assign row_coef = row_rotr(base_row, 2'(r));
      multiplicationcolumn u_mul (
         .column (cur_col),
         .coef   (row_coef),
         .result (col_result[31-8*r -: 8])
      );
   end

   // Latch the input on accept, then step the column counter and write each
   // computed column into the output register. Input changes after accept
   // never reach the datapath because only the latched copy is used.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q    <= '0;
         inverse_q <= 1'b0;
         col_q     <= 2'd0;
         result_q  <= '0;
      end else begin
         if (accept) begin
            data_q    <= in_state;
            inverse_q <= in_inverse;
            col_q     <= 2'd0;
         end
         if (run_step) begin
            col_q <= col_q + 2'd1;
            for (int c = 0; c < 4; c++) begin
               if (col_q == 2'(c)) result_q[127-32*c -: 32] <= col_result;
            end
         end
      end
   end

   assign out_state = result_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: directed AES vectors, backpressure,
// mid-block reset and randomized blocks against a matrix reference model.
module tb_mix_columns_seq;

   localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] VEC_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] VEC_C = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
   localparam logic [127:0] VEC_D = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         in_inverse;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   int checks = 0;
   int errors = 0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   mix_columns_seq dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_state   (in_state),
      .in_inverse (in_inverse),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_state  (out_state),
      .busy       (busy)
   );

   // Full 8x8 carry-less multiply followed by reduction modulo 0x11B.
   function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) prod = prod ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
      return prod[7:0];
   endfunction

   // Circulant-matrix product applied to every column of the state.
   function automatic logic [127:0] refMix(input logic [127:0] st, input logic inv);
      logic [7:0]   k0 [4];
      logic [7:0]   acc;
      logic [127:0] res;
      if (inv) k0 = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
      else     k0 = '{8'h02, 8'h03, 8'h01, 8'h01};
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++)
               acc = acc ^ refMul(k0[(j - r + 4) % 4], st[127-8*(4*c+j) -: 8]);
            res[127-8*(4*c+r) -: 8] = acc;
         end
      end
      return res;
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge, where outputs are settled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run one block end to end: accept, latency, optional stall in DONE while
   // junk is offered on the input side, then the output handshake.
   task automatic applyStimulus(input logic [127:0] st, input logic inv,
                                input int stallMin, input int stallMax,
                                output logic [127:0] result);
      logic [127:0] expected;
      int           waitCycles;
      int           lat;
      int           stall;
      expected   = refMix(st, inv);
      in_state   = st;
      in_inverse = inv;
      in_valid   = 1'b1;
      waitCycles = 0;
      while (!in_ready && waitCycles < 50) begin
         step();
         waitCycles++;
      end
      checkOutput("accept_ready", 128'(in_ready), 128'd1);
      step();
      in_valid = 1'b0;
      checkOutput("run_flags", 128'({out_valid, in_ready, busy}), 128'(3'b001));
      lat = 0;
      while (!out_valid && lat < 20) begin
         in_valid   = 1'($urandom);
         in_state   = {$urandom, $urandom, $urandom, $urandom};
         in_inverse = 1'($urandom);
         step();
         lat++;
      end
      checkOutput("latency", 128'(lat), 128'd4);
      stall = $urandom_range(stallMax, stallMin);
      for (int s = 0; s < stall; s++) begin
         checkOutput("hold_state", out_state, expected);
         checkOutput("hold_flags", 128'({out_valid, in_ready, busy}), 128'(3'b101));
         in_valid   = 1'b1;
         in_state   = {$urandom, $urandom, $urandom, $urandom};
         in_inverse = 1'($urandom);
         step();
      end
      checkOutput("result", out_state, expected);
      result    = out_state;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      checkOutput("idle_after", 128'({out_valid, in_ready, busy}), 128'(3'b010));
   endtask

   // Watchdog so the run always ends even if the design deadlocks.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence.
   initial begin
      logic [127:0] r1;
      logic [127:0] r2;
      logic [127:0] st;
      logic         inv;

      rst        = 1'b1;
      in_valid   = 1'b0;
      in_state   = '0;
      in_inverse = 1'b0;
      out_ready  = 1'b0;
      step();
      step();
      rst = 1'b0;
      checkOutput("reset_flags", 128'({out_valid, in_ready, busy}), 128'(3'b010));
      checkOutput("reset_state", out_state, 128'd0);

      applyStimulus(VEC_A, 1'b0, 0, 0, r1);
      checkOutput("fwd_vector", r1, VEC_B);
      applyStimulus(VEC_B, 1'b1, 0, 0, r1);
      checkOutput("inv_vector", r1, VEC_A);
      applyStimulus(VEC_A, 1'b0, 10, 10, r1);
      checkOutput("backpressure", r1, VEC_B);
      applyStimulus(VEC_C, 1'b0, 0, 0, r1);
      checkOutput("vector_c", r1, VEC_D);
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 0, r1);

      in_state   = VEC_C;
      in_inverse = 1'b0;
      in_valid   = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("abort_flags", 128'({out_valid, in_ready, busy}), 128'(3'b010));
      checkOutput("abort_state", out_state, 128'd0);
      applyStimulus(VEC_A, 1'b0, 0, 0, r1);
      checkOutput("after_abort", r1, VEC_B);

      for (int i = 0; i < 1000; i++) begin
         st  = {$urandom, $urandom, $urandom, $urandom};
         inv = 1'($urandom);
         applyStimulus(st, inv, 0, 3, r1);
         if (i % 8 == 0) begin
            applyStimulus(r1, ~inv, 0, 2, r2);
            checkOutput("roundtrip", r2, st);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
